// File: rtl/fc_stream_param_if.sv
// Valid/ready streams of the streaming FC layer: weights/activations in, results out.
interface fc_stream_param_if #(
    parameter int T = 16
);
    logic         input_valid;
    logic         input_ready;
    logic [T-1:0] input_data;
    logic         load_w;
    logic         output_valid;
    logic         output_ready;
    logic [T-1:0] output_data;

    modport master (
        output input_valid, input_data, load_w, output_ready,
        input  input_ready, output_valid, output_data
    );

    modport slave (
        input  input_valid, input_data, load_w, output_ready,
        output input_ready, output_valid, output_data
    );
endinterface

// File: rtl/fc_stream_param.sv
// Streaming fully-connected layer y = f(W*x): P saturating MAC lanes, each owning
// one weight bank (rows r with r%P == lane), sharing a single activation RAM.

module fc_stream_lane #(
    parameter int T  = 16,
    parameter int D  = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [T-1:0]  w_data,
    input  logic [AW-1:0] rd_addr,
    input  logic [T-1:0]  x_q,
    input  logic          prod_en,
    input  logic          acc_en,
    input  logic          acc_clr,
    output logic [T-1:0]  acc_nxt
);
    localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

    logic [T-1:0]          bank [D];
    logic signed [T-1:0]   w_q;
    logic signed [T-1:0]   prod;
    logic signed [T-1:0]   acc;
    logic signed [T-1:0]   prod_sat;
    logic signed [T-1:0]   sum;
    logic signed [2*T-1:0] full;

    // Weight bank is never reset; its contents are only meaningful after a load.
    always_ff @(posedge clk) begin
        if (w_we) bank[w_addr] <= w_data;
        w_q <= bank[rd_addr];
    end

    assign full = w_q * $signed(x_q);
    assign sum  = acc + prod;

    always_comb begin
        prod_sat = full[T-1:0];
        // Upper T+1 bits must all match for the product to fit in T bits.
        if (!((&full[2*T-1:T-1]) || !(|full[2*T-1:T-1])))
            prod_sat = full[2*T-1] ? SMIN : SMAX;
    end

    always_comb begin
        acc_nxt = acc;
        if (acc_en) begin
            if (acc[T-1] == prod[T-1] && sum[T-1] != acc[T-1])
                acc_nxt = acc[T-1] ? SMIN : SMAX;
            else
                acc_nxt = sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (prod_en) prod <= prod_sat;
            if (acc_clr) acc <= '0;
            else         acc <= acc_nxt;
        end
    end
endmodule

module fc_stream_param #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int P    = 2,
    parameter int RELU = 1
) (
    input logic              clk,
    input logic              reset,
    fc_stream_param_if.slave io
);
    localparam int D  = (M / P) * N;
    localparam int AW = $clog2(D);
    localparam int XW = $clog2(N);
    localparam int CW = $clog2(N + 2);
    localparam int WW = $clog2(M * N);
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (M / P > 1) ? $clog2(M / P) : 1;

    localparam logic [WW-1:0] WLAST = WW'(M * N - 1);
    localparam logic [XW-1:0] XLAST = XW'(N - 1);
    localparam logic [CW-1:0] CLAST = CW'(N + 1);
    localparam logic [CW-1:0] CISSUE = CW'(N);
    localparam logic [JW-1:0] JLAST = JW'(P - 1);
    localparam logic [GW-1:0] GLAST = GW'(M / P - 1);

    typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE, OUTPUT} state_t;

    state_t              state;
    logic [WW-1:0]       w_cnt;
    logic [XW-1:0]       w_col;
    logic [JW-1:0]       w_lane;
    logic [AW-1:0]       w_base;
    logic [XW-1:0]       x_cnt;
    logic [CW-1:0]       cnt;
    logic [GW-1:0]       g;
    logic [AW-1:0]       g_base;
    logic [JW-1:0]       j;
    logic [JW-1:0]       j_nxt;
    logic [1:0]          vld_pipe;
    logic                issue;
    logic                in_fire;
    logic                w_fire;
    logic                x_fire;
    logic                acc_clr;
    logic [AW-1:0]       w_addr;
    logic [AW-1:0]       rd_addr;
    logic [T-1:0]        x_ram [N];
    logic [T-1:0]        x_q;
    logic [P-1:0][T-1:0] acc_n;

    function automatic logic [T-1:0] relu(input logic [T-1:0] v);
        return (RELU != 0 && v[T-1]) ? '0 : v;
    endfunction

    // A load_w request at the start of a vector drops ready so that cycle moves no word.
    assign io.input_ready = reset && (state == LOAD_W ||
                            (state == LOAD_X && !(io.load_w && x_cnt == '0)));

    assign in_fire = io.input_valid && io.input_ready;
    assign w_fire  = in_fire && state == LOAD_W;
    assign x_fire  = in_fire && state == LOAD_X;
    assign issue   = state == COMPUTE && cnt < CISSUE;
    assign w_addr  = w_base + AW'(w_col);
    assign rd_addr = g_base + AW'(cnt);
    assign j_nxt   = j + 1'b1;
    assign acc_clr = (x_fire && x_cnt == XLAST) ||
                     (state == OUTPUT && io.output_ready && j == JLAST && g != GLAST);

    always_ff @(posedge clk) begin
        if (x_fire) x_ram[x_cnt] <= io.input_data;
        x_q <= x_ram[XW'(cnt)];
    end

    // vld_pipe[0]: RAM data valid, vld_pipe[1]: product valid (accumulate).
    for (genvar i = 0; i < P; i++) begin : g_lane
        fc_stream_lane #(.T(T), .D(D), .AW(AW)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .w_we    (w_fire && w_lane == JW'(i)),
            .w_addr  (w_addr),
            .w_data  (io.input_data),
            .rd_addr (rd_addr),
            .x_q     (x_q),
            .prod_en (vld_pipe[0]),
            .acc_en  (vld_pipe[1]),
            .acc_clr (acc_clr),
            .acc_nxt (acc_n[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= LOAD_W;
            w_cnt           <= '0;
            w_col           <= '0;
            w_lane          <= '0;
            w_base          <= '0;
            x_cnt           <= '0;
            cnt             <= '0;
            g               <= '0;
            g_base          <= '0;
            j               <= '0;
            vld_pipe        <= '0;
            io.output_valid <= 1'b0;
            io.output_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue};
            case (state)
                LOAD_W: if (w_fire) begin
                    if (w_cnt == WLAST) begin
                        w_cnt  <= '0;
                        w_col  <= '0;
                        w_lane <= '0;
                        w_base <= '0;
                        state  <= LOAD_X;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                        if (w_col == XLAST) begin
                            w_col <= '0;
                            if (w_lane == JLAST) begin
                                w_lane <= '0;
                                w_base <= w_base + AW'(N);
                            end else begin
                                w_lane <= w_lane + 1'b1;
                            end
                        end else begin
                            w_col <= w_col + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (io.load_w && x_cnt == '0) begin
                        state <= LOAD_W;
                    end else if (x_fire) begin
                        if (x_cnt == XLAST) begin
                            x_cnt  <= '0;
                            cnt    <= '0;
                            g      <= '0;
                            g_base <= '0;
                            state  <= COMPUTE;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (cnt == CLAST) begin
                        // Lane 0's final accumulate lands this same edge, so take the next value.
                        cnt             <= '0;
                        j               <= '0;
                        io.output_valid <= 1'b1;
                        io.output_data  <= relu(acc_n[0]);
                        state           <= OUTPUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUTPUT: if (io.output_ready) begin
                    if (j == JLAST) begin
                        j               <= '0;
                        io.output_valid <= 1'b0;
                        io.output_data  <= '0;
                        if (g == GLAST) begin
                            g      <= '0;
                            g_base <= '0;
                            state  <= LOAD_X;
                        end else begin
                            g      <= g + 1'b1;
                            g_base <= g_base + AW'(N);
                            state  <= COMPUTE;
                        end
                    end else begin
                        j              <= j_nxt;
                        io.output_data <= relu(acc_n[j_nxt]);
                    end
                end
                default: state <= LOAD_W;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_stream_param.sv
// Directed bench for fc_stream_param: M=4,N=3,T=8,P=2,RELU=1 with hand-computed results.
module tb_fc_stream_param;
    localparam int M = 4, N = 3, T = 8, P = 2, RELU = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fc_stream_param_if #(.T(T)) bus ();

    fc_stream_param #(.M(M), .N(N), .T(T), .P(P), .RELU(RELU)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    int w_orig [12] = '{1, 2, 3, -1, 0, 1, 10, 10, 10, 2, -3, 1};
    int w_ones [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the word until accepted; returns #1 after the transfer edge with valid still high.
    task automatic send(input int d);
        int n = 0;
        bus.input_valid = 1'b1;
        bus.input_data  = d[T-1:0];
        #0;
        while (!bus.input_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        tick();
    endtask

    task automatic load_weights(input int w [12]);
        for (int i = 0; i < 12; i++) send(w[i]);
        bus.input_valid = 1'b0;
    endtask

    task automatic send_x(input int a, input int b, input int c);
        send(a);
        send(b);
        send(c);
        bus.input_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int exp, input int stall);
        int n = 0;
        logic [T-1:0] held;
        bit stable;
        while (!bus.output_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, bus.output_valid, 1);
        chk(tag, $signed(bus.output_data), exp);
        if (stall > 0) begin
            held   = bus.output_data;
            stable = 1'b1;
            repeat (stall) begin
                tick();
                if (bus.output_valid !== 1'b1 || bus.output_data !== held) stable = 1'b0;
            end
            chk({tag, "_hold"}, stable, 1);
        end
        bus.output_ready = 1'b1;
        tick();
        bus.output_ready = 1'b0;
    endtask

    task automatic recv4(input string tag, input int a, input int b, input int c, input int d, input int stall);
        recv({tag, "_y0"}, a, stall);
        recv({tag, "_y1"}, b, stall);
        recv({tag, "_y2"}, c, stall);
        recv({tag, "_y3"}, d, stall);
    endtask

    initial begin
        int lat;
        bus.input_valid  = 1'b0;
        bus.input_data   = '0;
        bus.load_w       = 1'b0;
        bus.output_ready = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", bus.input_ready, 0);
        chk("rst_ovalid", bus.output_valid, 0);
        chk("rst_odata", bus.output_data, 0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("rel_ready", bus.input_ready, 1);

        // Basic vector plus first-result latency (N+2 edges after the last x edge)
        load_weights(w_orig);
        send_x(1, 1, 2);
        chk("compute_ready", bus.input_ready, 0);
        lat = 0;
        while (!bus.output_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", lat, N + 2);
        recv4("v112", 9, 1, 40, 1, 0);

        // Product and accumulator saturation
        send_x(100, 100, 100);
        recv4("v100", 127, 0, 127, 99, 0);

        // ReLU clamps row 1 (-2)
        send_x(2, 0, 0);
        recv4("v200", 2, 0, 20, 4, 0);

        // Backpressure: hold each result 5 cycles, then reuse weights for another vector
        send_x(1, 1, 2);
        recv4("bp", 9, 1, 40, 1, 5);
        send_x(2, 0, 0);
        recv4("reuse", 2, 0, 20, 4, 2);

        // Reload: load_w at start of LOAD_X drops ready and returns to LOAD_W
        bus.load_w      = 1'b1;
        bus.input_valid = 1'b1;
        bus.input_data  = 8'd99;
        #1;
        chk("loadw_ready", bus.input_ready, 0);
        tick();
        bus.load_w      = 1'b0;
        bus.input_valid = 1'b0;
        #1;
        chk("loadw_state_ready", bus.input_ready, 1);
        load_weights(w_ones);
        send(1);
        bus.load_w = 1'b1;
        #1;
        chk("loadw_ignored_ready", bus.input_ready, 1);
        send(1);
        bus.load_w = 1'b0;
        send(2);
        bus.input_valid = 1'b0;
        recv4("ones", 4, 4, 4, 4, 0);

        // Reset mid-COMPUTE, then full reload
        send_x(1, 1, 2);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ovalid", bus.output_valid, 0);
        chk("midrst_ready", bus.input_ready, 0);
        tick();
        tick();
        chk("midrst_ready_hold", bus.input_ready, 0);
        reset = 1'b1;
        #1;
        chk("midrst_rel_ready", bus.input_ready, 1);
        load_weights(w_orig);
        send_x(1, 1, 2);
        recv4("after_rst", 9, 1, 40, 1, 0);

        // Reset while a result is presented clears it without waiting for a clock
        send_x(1, 1, 2);
        lat = 0;
        while (!bus.output_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("outrst_pre_valid", bus.output_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("outrst_ovalid", bus.output_valid, 0);
        chk("outrst_odata", bus.output_data, 0);
        tick();
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_stream_param.md
# fc_stream_param

Parametrised streaming fully-connected layer: computes y = f(W·x) for an M×N signed weight matrix held in on-chip RAM and an N-element input vector, with P parallel saturating MAC lanes. Weights and activations arrive on one valid/ready input stream; the M results leave in row order on a valid/ready output stream. This is the generic layer engine for chaining FC layers, with runtime-loadable weights and optional ReLU.

## Interface
- M, 8, output rows; M % P == 0 required
- N, 8, input vector length, ≥ 2
- T, 16, data width (signed two's complement)
- P, 2, parallel MAC lanes; rows processed in groups of P
- RELU, 1, 1 = clamp negative results to 0 at output; 0 = pass through

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; whole block
- input_valid  in  1  input word valid
- input_ready  out  1  block accepts input word this cycle
- input_data  in  T  weight or activation word
- load_w  in  1  request weight reload; sampled in LOAD_X only
- output_valid  out  1  output_data holds a result
- output_ready  in  1  downstream accepts result
- output_data  out  T  result y[r]

## Operation
- Transfers occur on cycles where valid && ready are both high; no registered/delayed ready.
- States: LOAD_W, LOAD_X, COMPUTE, OUTPUT.
- LOAD_W: input_ready=1. Accept M·N weights, row-major (W[0][0..N-1], W[1][0..N-1], …). Word for row r goes to bank r%P at address (r/P)·N + k. After the M·N-th word → LOAD_X.
- LOAD_X: input_ready=1. Accept N activations into x RAM at index 0..N-1. If load_w=1 while zero activations of the current vector have been accepted → LOAD_W (weights overwritten; the load_w cycle accepts no word). load_w ignored once ≥1 activation accepted. After N-th word → COMPUTE, group g=0.
- COMPUTE: input_ready=0. Accumulators cleared on entry. Pipeline: issue x/W address k (cycle k), RAM data (k+1), product register (k+2), accumulate (k+2). Occupies exactly N+2 cycles, then → OUTPUT.
- Arithmetic per lane: T×T signed product (2T bits) saturated to [−2^(T−1), 2^(T−1)−1]; then acc + product saturated to same range (overflow when operand signs equal and result sign differs).
- OUTPUT: output_valid=1; output_data = lane j accumulator of row g·P+j, j=0..P−1 in order, ReLU applied if RELU=1. j advances only on output_ready. After lane P−1 transfers: if g < M/P−1 → COMPUTE with g+1 (x RAM reused); else → LOAD_X.
- Weights persist across vectors; only LOAD_W rewrites them.

## Timing
- Reset (reset=0, async): state=LOAD_W, all counters 0, accumulators 0, output_valid=0, output_data=0, input_ready forced 0 while reset low; input_ready=1 the first cycle after release. RAM contents not cleared; deemed invalid.
- Reset mid-operation (any state): immediate return to above; partial vector and partial results discarded, no output_valid glitch.
- Last activation accepted in cycle c → COMPUTE c+1..c+N+2 → output_valid=1 from c+N+3.
- Per group: N+2 compute cycles + P output cycles minimum. Full vector with no backpressure: N (load) + (M/P)·(N+2+P) cycles.
- Backpressure: output_valid and output_data held stable while output_ready=0; no result lost or duplicated.
- input_valid during COMPUTE/OUTPUT: ignored (input_ready=0); upstream holds word.
- Wrap-around: weight and x address counters reset to 0 at end of each load; group counter resets after last group.

## Test plan
- M=4,N=3,T=8,P=2,RELU=1; W rows [1,2,3],[−1,0,1],[10,10,10],[2,−3,1]; x=[1,1,2] → outputs 9,1,40,1 in order; first output_valid exactly N+3=6 cycles after last x accepted.
- Same W, x=[100,100,100] → 127,0,127,99 (product and accumulator saturation both exercised).
- Same W, x=[2,0,0] → 2,0,20,4 with RELU=1; RELU=0 build → 2,−2,20,4.
- Backpressure: output_ready low 5 cycles on each result, random toggling → identical sequence 9,1,40,1, data stable while stalled; then a second vector without reload reuses weights correctly.
- Reload: load_w=1 at start of LOAD_X, new W all 1 → x=[1,1,2] gives 4,4,4,4; load_w asserted after first activation accepted is ignored.
- Reset low mid-COMPUTE → output_valid=0 immediately, input_ready=0 until release, then block in LOAD_W accepting weights; full reload and vector produce correct results.
